// File: rtl/hps_io_pkg.sv
// hps_io_pkg: shared types for the HPS IO frame sequencer.
// FSM states, target codes, gp_out enable bits, err bit indices.
package hps_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_CONFLICT
  } state_e;

  localparam logic [1:0] TGT_NONE = 2'd0;
  localparam logic [1:0] TGT_IO   = 2'd1;
  localparam logic [1:0] TGT_OSD  = 2'd2;
  localparam logic [1:0] TGT_FPGA = 2'd3;

  localparam int EN_IO   = 20;
  localparam int EN_OSD  = 19;
  localparam int EN_FPGA = 18;

  localparam int ERR_MULTI  = 0;
  localparam int ERR_ORPHAN = 1;
  localparam int ERR_OVF    = 2;

  // Enable vector layout is {io, osd, fpga}.
  function automatic logic [2:0] tgt_mask(input logic [1:0] t);
    logic [2:0] m;
    m = 3'b000;
    case (t)
      TGT_IO:   m = 3'b100;
      TGT_OSD:  m = 3'b010;
      TGT_FPGA: m = 3'b001;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hps_frame_counter.sv
// hps_frame_counter: payload word counter, saturating at 2^IDX_W.
// Ports: clr/inc/cap controls; idx (clamped), full, frame_len capture.
module hps_frame_counter
  import hps_io_pkg::*;
#(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             cap,
  output logic [IDX_W-1:0] idx,
  output logic             full,
  output logic [IDX_W:0]   frame_len
);

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] len_q, len_d;
  logic [IDX_W:0] frame_len_q, frame_len_d;

  // len counts words received; MSB set means 2^IDX_W words seen.
  assign full = len_q[IDX_W];
  assign idx  = full ? {IDX_W{1'b1}} : len_q[IDX_W-1:0];
  assign frame_len = frame_len_q;

  always_comb begin
    len_d = len_q;
    if (clr) begin
      len_d = '0;
    end else if (inc && !full) begin
      len_d = len_q + ONE;
    end
  end

  always_comb begin
    frame_len_d = frame_len_q;
    if (cap) begin
      frame_len_d = len_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      frame_len_q <= '0;
    end else begin
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
    end
  end

endmodule

// File: rtl/hps_io_sequencer.sv
// hps_io_sequencer: decodes the HPS SPI word stream into cmd/data/end
// frames and muxes the active target's response onto gp_in.
module hps_io_sequencer
  import hps_io_pkg::*;
#(
  parameter int          IDX_W       = 12,
  parameter logic [15:0] STATUS_WORD = 16'h5A01
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [31:0]      gp_out,
  input  logic             io_strobe,
  output logic [15:0]      gp_in,
  output logic [1:0]       target,
  output logic [15:0]      cmd,
  output logic             cmd_valid,
  output logic [15:0]      data,
  output logic             data_valid,
  output logic [IDX_W-1:0] data_idx,
  output logic             frame_end,
  output logic [IDX_W:0]   frame_len,
  input  logic [15:0]      resp_io,
  input  logic [15:0]      resp_osd,
  input  logic [15:0]      resp_fpga,
  output logic [2:0]       err
);

  state_e state_q, state_d;

  logic       close_pend_q, close_pend_d;
  logic [15:0] gp_in_q, gp_in_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_end_q, frame_end_d;
  logic [IDX_W-1:0] data_idx_q, data_idx_d;
  logic [1:0] target_q, target_d;
  logic [2:0] err_q, err_d;

  logic [2:0] en;
  logic [2:0] mask;
  logic [1:0] en_tgt;
  logic       any_en, multi, act_en, foreign;
  logic       in_frame, conflict_hit, take_word, closing;

  logic             cnt_clr, cnt_inc, cnt_cap, cnt_full;
  logic [IDX_W-1:0] cnt_idx;

  logic unused_gp;
  assign unused_gp = ^{gp_out[31:21], gp_out[17:16]};

  assign en      = {gp_out[EN_IO], gp_out[EN_OSD], gp_out[EN_FPGA]};
  assign mask    = tgt_mask(target_q);
  assign any_en  = |en;
  assign multi   = (en & (en - 3'd1)) != 3'd0;
  assign act_en  = |(en & mask);
  assign foreign = |(en & ~mask);

  always_comb begin
    en_tgt = TGT_NONE;
    if (en[2]) begin
      en_tgt = TGT_IO;
    end else if (en[1]) begin
      en_tgt = TGT_OSD;
    end else if (en[0]) begin
      en_tgt = TGT_FPGA;
    end
  end

  // A word on the closing cycle still belongs to the frame; the close
  // is deferred one cycle through close_pend.
  assign in_frame     = (state_q == ST_CMD) || (state_q == ST_DATA);
  assign conflict_hit = in_frame && foreign;
  assign take_word    = in_frame && !foreign && io_strobe &&
                        !close_pend_q;
  assign closing      = in_frame && !foreign && !take_word &&
                        (close_pend_q || !act_en);
  assign close_pend_d = take_word && !act_en;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      close_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      close_pend_q <= close_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (multi) begin
          state_d = ST_CONFLICT;
        end else if (any_en) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD, ST_DATA: begin
        if (conflict_hit) begin
          state_d = ST_CONFLICT;
        end else if (closing) begin
          state_d = ST_IDLE;
        end else if (take_word) begin
          state_d = ST_DATA;
        end
      end
      ST_CONFLICT: begin
        if (!any_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    data_d       = data_q;
    data_valid_d = 1'b0;
    data_idx_d   = data_idx_q;
    frame_end_d  = 1'b0;
    target_d     = target_q;
    err_d        = err_q;
    cnt_inc      = 1'b0;
    cnt_cap      = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (multi) begin
          err_d[ERR_MULTI] = 1'b1;
        end else if (any_en) begin
          target_d = en_tgt;
        end
        if (io_strobe) begin
          err_d[ERR_ORPHAN] = 1'b1;
        end
      end
      conflict_hit || closing: begin
        frame_end_d = 1'b1;
        cnt_cap     = 1'b1;
        target_d    = TGT_NONE;
        if (conflict_hit) begin
          err_d[ERR_MULTI] = 1'b1;
        end
      end
      take_word && state_q == ST_CMD: begin
        cmd_d       = gp_out[15:0];
        cmd_valid_d = 1'b1;
      end
      take_word && state_q == ST_DATA: begin
        data_d       = gp_out[15:0];
        data_idx_d   = cnt_idx;
        data_valid_d = 1'b1;
        cnt_inc      = 1'b1;
        // Word arriving after 2^IDX_W words already counted.
        if (cnt_full) begin
          err_d[ERR_OVF] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Response mux keyed on registered state/target only, so gp_in
  // moves only on those or on the selected resp_* input.
  always_comb begin
    gp_in_d = 16'h0000;
    unique case (state_q)
      ST_CMD: gp_in_d = STATUS_WORD;
      ST_DATA: begin
        unique case (target_q)
          TGT_IO:   gp_in_d = resp_io;
          TGT_OSD:  gp_in_d = resp_osd;
          TGT_FPGA: gp_in_d = resp_fpga;
          default:  gp_in_d = 16'h0000;
        endcase
      end
      default: gp_in_d = 16'h0000;
    endcase
  end

  assign cnt_clr = state_q != ST_DATA;

  hps_frame_counter #(
    .IDX_W (IDX_W)
  ) u_cnt (
    .clk       (sys_clk),
    .rst_n     (reset_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .cap       (cnt_cap),
    .idx       (cnt_idx),
    .full      (cnt_full),
    .frame_len (frame_len)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      gp_in_q      <= '0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      data_idx_q   <= '0;
      frame_end_q  <= 1'b0;
      target_q     <= TGT_NONE;
      err_q        <= '0;
    end else begin
      gp_in_q      <= gp_in_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      data_idx_q   <= data_idx_d;
      frame_end_q  <= frame_end_d;
      target_q     <= target_d;
      err_q        <= err_d;
    end
  end

  assign gp_in      = gp_in_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign data_idx   = data_idx_q;
  assign frame_end  = frame_end_q;
  assign target     = target_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hps_io_sequencer.sv
// tb_hps_io_sequencer: directed and randomized frames for hps_io_sequencer
// with a queue-based frame model of expected cmd/data/frame_end events.
module tb_hps_io_sequencer;

  localparam int IDX_W = 3;
  localparam int MAXI  = (1 << IDX_W) - 1;
  localparam int FULLN = 1 << IDX_W;
  localparam logic [15:0] STATUS = 16'h5A01;

  logic             clk;
  logic             rst_n;
  logic [31:0]      gp_out;
  logic             io_strobe;
  logic [15:0]      gp_in;
  logic [1:0]       target;
  logic [15:0]      cmd;
  logic             cmd_valid;
  logic [15:0]      data;
  logic             data_valid;
  logic [IDX_W-1:0] data_idx;
  logic             frame_end;
  logic [IDX_W:0]   frame_len;
  logic [15:0]      resp_io, resp_osd, resp_fpga;
  logic [2:0]       err;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_err;

  logic [15:0] pay[$];
  logic [15:0] mon_cmd[$];
  logic [15:0] mon_data[$];
  int          mon_idx[$];
  int          mon_len[$];

  hps_io_sequencer #(
    .IDX_W       (IDX_W),
    .STATUS_WORD (STATUS)
  ) dut (
    .sys_clk    (clk),
    .reset_n    (rst_n),
    .gp_out     (gp_out),
    .io_strobe  (io_strobe),
    .gp_in      (gp_in),
    .target     (target),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .data       (data),
    .data_valid (data_valid),
    .data_idx   (data_idx),
    .frame_end  (frame_end),
    .frame_len  (frame_len),
    .resp_io    (resp_io),
    .resp_osd   (resp_osd),
    .resp_fpga  (resp_fpga),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) mon_cmd.push_back(cmd);
      if (data_valid) begin
        mon_data.push_back(data);
        mon_idx.push_back(int'(data_idx));
      end
      if (frame_end) mon_len.push_back(int'(frame_len));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [2:0] e);
    gp_out[20:18] = e;
  endtask

  task automatic send_word(input logic [15:0] w);
    gp_out[15:0] = w;
    io_strobe = 1'b1;
    step();
    io_strobe = 1'b0;
  endtask

  task automatic mon_clear();
    mon_cmd.delete();
    mon_data.delete();
    mon_idx.delete();
    mon_len.delete();
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_gp_in"}, gp_in, 0);
    chk({p, "_target"}, target, 0);
    chk({p, "_cmd"}, cmd, 0);
    chk({p, "_data"}, data, 0);
    chk({p, "_pulses"}, {cmd_valid, data_valid, frame_end}, 0);
    chk({p, "_idx_len"}, {data_idx, frame_len}, 0);
    chk({p, "_err"}, err, 0);
  endtask

  function automatic logic [15:0] resp_of(input int t);
    case (t)
      1:       return resp_io;
      2:       return resp_osd;
      default: return resp_fpga;
    endcase
  endfunction

  function automatic logic [2:0] en_of(input int t);
    case (t)
      1:       return 3'b100;
      2:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // One frame: optional command word, then the words in pay.
  // dwl drops the enable in the same cycle as the last word.
  task automatic do_frame(input int tgt, input bit has_cmd,
                          input logic [15:0] c, input bit dwl);
    int n;
    int explen;
    logic [15:0] r;
    logic [15:0] gexp;
    bit last_drop;
    n = pay.size();
    r = resp_of(tgt);
    last_drop = has_cmd && dwl;
    explen = has_cmd ? ((n < FULLN) ? n : FULLN) : 0;
    gexp = (!has_cmd || (n == 0 && !dwl)) ? STATUS : r;
    mon_clear();
    set_en(en_of(tgt));
    step();
    chk("tgt_open", target, tgt);
    if (!has_cmd) begin
      step();
      chk("gp_cmd", gp_in, STATUS);
    end else begin
      if (dwl && n == 0) set_en(3'b000);
      send_word(c);
      for (int i = 0; i < n; i++) begin
        if (dwl && i == n - 1) set_en(3'b000);
        send_word(pay[i]);
        if (i == 0) chk("gp_data", gp_in, r);
      end
    end
    if (!last_drop) set_en(3'b000);
    step();
    chk("fe_pulse", frame_end, 1);
    chk("fe_len", frame_len, explen);
    chk("fe_target", target, 0);
    chk("fe_gp_in", gp_in, gexp);
    step();
    chk("post_gp_in", gp_in, 0);
    chk("post_fe", frame_end, 0);
    chk("n_cmd", mon_cmd.size(), has_cmd ? 1 : 0);
    if (has_cmd && mon_cmd.size() > 0) begin
      chk("cmd_val", mon_cmd[0], c);
      chk("cmd_held", cmd, c);
    end
    chk("n_data", mon_data.size(), n);
    for (int i = 0; i < n && i < mon_data.size(); i++) begin
      chk("data_val", mon_data[i], pay[i]);
      chk("data_idx", mon_idx[i], (i < MAXI) ? i : MAXI);
    end
    chk("n_end", mon_len.size(), 1);
    if (mon_len.size() > 0) chk("len_mon", mon_len[0], explen);
    if (has_cmd && n > FULLN) exp_err[2] = 1'b1;
    chk("err_frame", err, exp_err);
  endtask

  initial begin
    int t;
    int n;
    logic [15:0] w;
    clk = 1'b0;
    rst_n = 1'b0;
    gp_out = $urandom;
    gp_out[20:18] = 3'b000;
    io_strobe = 1'b0;
    resp_io = 16'($urandom);
    resp_osd = 16'($urandom);
    resp_fpga = 16'($urandom);
    exp_err = 3'b000;
    repeat (3) step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();
    chk_zero("idle");

    pay.delete();
    pay.push_back(16'h1234);
    pay.push_back(16'hBEEF);
    do_frame(1, 1'b1, 16'h0018, 1'b0);

    pay.delete();
    do_frame(2, 1'b0, 16'h0000, 1'b0);

    resp_fpga = 16'hCAFE;
    pay.delete();
    pay.push_back(16'($urandom));
    pay.push_back(16'($urandom));
    do_frame(3, 1'b1, 16'($urandom), 1'b0);

    for (int k = 0; k < 8; k++) begin
      resp_io = 16'($urandom);
      resp_osd = 16'($urandom);
      resp_fpga = 16'($urandom);
      t = int'($urandom_range(1, 3));
      n = int'($urandom_range(0, MAXI));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(16'($urandom));
      do_frame(t, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Two enables rising together from IDLE.
    mon_clear();
    set_en(3'b110);
    step();
    exp_err[0] = 1'b1;
    chk("conf_err", err, 3'b001);
    repeat (3) send_word(16'($urandom));
    chk("conf_gp_in", gp_in, 0);
    set_en(3'b010);
    step();
    send_word(16'($urandom));
    set_en(3'b000);
    step();
    step();
    chk("conf_pulses", mon_cmd.size() + mon_data.size() + mon_len.size(), 0);
    chk("conf_err_hold", err, exp_err);
    pay.delete();
    pay.push_back(16'($urandom));
    do_frame(2, 1'b1, 16'($urandom), 1'b0);

    // Second enable rising during DATA closes the frame.
    mon_clear();
    set_en(3'b100);
    step();
    send_word(16'($urandom));
    w = 16'($urandom);
    send_word(w);
    set_en(3'b110);
    step();
    chk("mid_fe", frame_end, 1);
    chk("mid_len", frame_len, 1);
    chk("mid_target", target, 0);
    send_word(16'($urandom));
    send_word(16'($urandom));
    chk("mid_err", err, exp_err);
    set_en(3'b000);
    step();
    step();
    chk("mid_n_data", mon_data.size(), 1);
    chk("mid_n_end", mon_len.size(), 1);
    if (mon_data.size() > 0) chk("mid_data", mon_data[0], w);

    // Overflow: 10 payload words through a 3-bit index.
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(16'($urandom));
    do_frame(int'($urandom_range(1, 3)), 1'b1, 16'($urandom), 1'b0);
    chk("ovf_err", err[2], 1);

    // Strobe with no frame open.
    mon_clear();
    send_word(16'($urandom));
    step();
    exp_err[1] = 1'b1;
    chk("orphan_err", err, exp_err);
    chk("orphan_pulses", mon_cmd.size() + mon_data.size() + mon_len.size(), 0);

    // Reset mid-DATA.
    resp_io = 16'($urandom) | 16'h0001;
    set_en(3'b100);
    step();
    send_word(16'($urandom));
    send_word(16'($urandom));
    send_word(16'($urandom));
    step();
    chk("pre_rst_gp", gp_in, resp_io);
    mon_clear();
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    set_en(3'b000);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_no_fe", mon_len.size(), 0);
    exp_err = 3'b000;
    pay.delete();
    pay.push_back(16'($urandom));
    pay.push_back(16'($urandom));
    do_frame(1, 1'b1, 16'($urandom), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
